// File: rtl/clock_ctrl.sv
// clock_ctrl: hours/minutes/seconds time-of-day counter with a three-state
// set mode (RUN -> SET_HOUR -> SET_MIN -> RUN) and a blink request for the
// field being adjusted.
//
// Parameters
//   HOUR_MAX   last hour value before the hour counter wraps to 0 (1..31)
// Ports
//   clk        single clock, all state updates on its rising edge
//   rst        asynchronous, active-high reset
//   tick       one-cycle 1 Hz time-base enable
//   btn_mode   one-cycle mode-advance pulse (pre-debounced)
//   btn_inc    one-cycle increment pulse (pre-debounced)
//   sec        seconds, 0..59
//   min        minutes, 0..59
//   hour       hours, 0..HOUR_MAX
//   mode       current state: 0=RUN, 1=SET_HOUR, 2=SET_MIN
//   blink      display-blank request for the field being set
//   day_pulse  one-cycle pulse on day rollover
module clock_ctrl #(
  parameter int unsigned HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_pulse
);

  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned HOUR_W = 5;

  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(59);
  localparam logic [MIN_W-1:0]  MIN_LAST  = MIN_W'(59);
  localparam logic [HOUR_W-1:0] HOUR_LAST = HOUR_W'(HOUR_MAX);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

  state_t              r_state;
  logic [SEC_W-1:0]    r_sec;
  logic [MIN_W-1:0]    r_min;
  logic [HOUR_W-1:0]   r_hour;
  logic                r_blink;
  logic                r_day_pulse;

  // Mode FSM, time counters and blink; btn_mode outranks btn_inc, which outranks tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_sec       <= '0;
      r_min       <= '0;
      r_hour      <= '0;
      r_blink     <= 1'b0;
      r_day_pulse <= 1'b0;
    end else begin
      r_day_pulse <= 1'b0;
      case (r_state)
        RUN: begin
          r_blink <= 1'b0;
          if (btn_mode) begin
            // Entering set mode freezes the seconds at zero.
            r_state <= SET_HOUR;
            r_sec   <= '0;
          end else if (tick) begin
            if (r_sec == SEC_LAST) begin
              r_sec <= '0;
              if (r_min == MIN_LAST) begin
                r_min <= '0;
                if (r_hour == HOUR_LAST) begin
                  r_hour      <= '0;
                  r_day_pulse <= 1'b1;
                end else begin
                  r_hour <= r_hour + HOUR_W'(1);
                end
              end else begin
                r_min <= r_min + MIN_W'(1);
              end
            end else begin
              r_sec <= r_sec + SEC_W'(1);
            end
          end
        end

        SET_HOUR: begin
          if (btn_mode) begin
            r_state <= SET_MIN;
            r_blink <= 1'b0;
          end else if (btn_inc) begin
            // Show the field immediately after each adjustment.
            r_hour  <= (r_hour == HOUR_LAST) ? '0 : r_hour + HOUR_W'(1);
            r_blink <= 1'b0;
          end else if (tick) begin
            r_blink <= ~r_blink;
          end
        end

        SET_MIN: begin
          if (btn_mode) begin
            r_state <= RUN;
            r_blink <= 1'b0;
          end else if (btn_inc) begin
            r_min   <= (r_min == MIN_LAST) ? '0 : r_min + MIN_W'(1);
            r_blink <= 1'b0;
          end else if (tick) begin
            r_blink <= ~r_blink;
          end
        end

        default: begin
          // Unused encoding recovers to RUN.
          r_state <= RUN;
          r_blink <= 1'b0;
        end
      endcase
    end
  end

  assign sec       = r_sec;
  assign min       = r_min;
  assign hour      = r_hour;
  assign mode      = r_state;
  assign blink     = r_blink;
  assign day_pulse = r_day_pulse;

endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: directed stimulus for clock_ctrl, checked every cycle against
// a time-of-day model kept as plain integers, plus literal checkpoints.
module tb_clock_ctrl;

  localparam int HM = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink;
  logic       day_pulse;

  int vec_cnt = 0;
  int err_cnt = 0;

  clock_ctrl #(.HOUR_MAX(HM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec(sec), .min(min), .hour(hour), .mode(mode), .blink(blink),
    .day_pulse(day_pulse)
  );

  always #5 clk = ~clk;

  // Model: time kept as h/m/s integers, RUN advances via seconds-of-day arithmetic.
  int m_h = 0, m_m = 0, m_s = 0, m_mode = 0;
  bit m_blink = 0, m_day = 0;

  always @(posedge clk or posedge rst) begin
    int total;
    if (rst) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_day = 0;
    end else begin
      m_day = 0;
      if (btn_mode) begin
        if (m_mode == 0) m_s = 0;
        m_mode  = (m_mode + 1) % 3;
        m_blink = 0;
      end else if (m_mode != 0 && btn_inc) begin
        if (m_mode == 1) m_h = (m_h + 1) % (HM + 1);
        else             m_m = (m_m + 1) % 60;
        m_blink = 0;
      end else if (tick) begin
        if (m_mode == 0) begin
          total = m_h * 3600 + m_m * 60 + m_s + 1;
          if (total == (HM + 1) * 3600) begin
            total = 0;
            m_day = 1;
          end
          m_h = total / 3600;
          m_m = (total / 60) % 60;
          m_s = total % 60;
        end else begin
          m_blink = ~m_blink;
        end
      end
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    vec_cnt++;
    if (int'(hour) != m_h || int'(min) != m_m || int'(sec) != m_s ||
        int'(mode) != m_mode || blink != m_blink || day_pulse != m_day) begin
      err_cnt++;
      $display("FAIL cycle @%0t: got %0d:%0d:%0d mode=%0d blink=%0d day=%0d, want %0d:%0d:%0d mode=%0d blink=%0d day=%0d",
               $time, hour, min, sec, mode, blink, day_pulse,
               m_h, m_m, m_s, m_mode, m_blink, m_day);
    end
  end

  // Literal checkpoint against both the DUT and the model.
  task automatic chk(input string name, input int h, input int mi, input int s,
                     input int md, input int bl, input int dp);
    vec_cnt++;
    if (int'(hour) != h || int'(min) != mi || int'(sec) != s ||
        int'(mode) != md || int'(blink) != bl || int'(day_pulse) != dp) begin
      err_cnt++;
      $display("FAIL %s dut: got %0d:%0d:%0d mode=%0d blink=%0d day=%0d, want %0d:%0d:%0d mode=%0d blink=%0d day=%0d",
               name, hour, min, sec, mode, blink, day_pulse, h, mi, s, md, bl, dp);
    end
    vec_cnt++;
    if (m_h != h || m_m != mi || m_s != s || m_mode != md ||
        int'(m_blink) != bl || int'(m_day) != dp) begin
      err_cnt++;
      $display("FAIL %s model: got %0d:%0d:%0d mode=%0d blink=%0d day=%0d, want %0d:%0d:%0d mode=%0d blink=%0d day=%0d",
               name, m_h, m_m, m_s, m_mode, m_blink, m_day, h, mi, s, md, bl, dp);
    end
  endtask

  task automatic step(input bit t, input bit md, input bit inc);
    tick = t; btn_mode = md; btn_inc = inc;
    @(posedge clk);
    #1;
    tick = 0; btn_mode = 0; btn_inc = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1);
  endtask

  task automatic mode_btn();
    step(0, 1, 0);
  endtask

  initial begin
    #1;
    chk("reset_hold", 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk);
    #3 rst = 0;
    @(posedge clk); #1;
    chk("after_reset", 0, 0, 0, 0, 0, 0);
    ticks(1);
    chk("first_tick", 0, 0, 1, 0, 0, 0);

    // Preset 05:07:00 then count to 05:07:33.
    mode_btn(); incs(5); mode_btn(); incs(7); mode_btn();
    chk("preset_0507", 5, 7, 0, 0, 0, 0);
    ticks(33);
    chk("run_050733", 5, 7, 33, 0, 0, 0);
    mode_btn();
    chk("enter_set_hour", 5, 7, 0, 1, 0, 0);
    incs(20);
    chk("hour_wrap", 1, 7, 0, 1, 0, 0);
    mode_btn(); incs(3);
    chk("min_inc", 1, 10, 0, 2, 0, 0);
    mode_btn();
    chk("back_to_run", 1, 10, 0, 0, 0, 0);

    // Minute carry 10:59:59 -> 11:00:00.
    mode_btn(); incs(9); mode_btn(); incs(49); mode_btn();
    ticks(59);
    chk("run_105959", 10, 59, 59, 0, 0, 0);
    ticks(1);
    chk("min_carry", 11, 0, 0, 0, 0, 0);

    // Day rollover 23:59:59 -> 00:00:00.
    mode_btn(); incs(12); mode_btn(); incs(59); mode_btn();
    ticks(59);
    chk("run_235959", 23, 59, 59, 0, 0, 0);
    ticks(1);
    chk("day_roll", 0, 0, 0, 0, 0, 1);
    step(0, 0, 0);
    chk("day_pulse_end", 0, 0, 0, 0, 0, 0);

    // Coincident events in RUN.
    step(0, 0, 1);
    chk("inc_ignored_run", 0, 0, 0, 0, 0, 0);
    step(0, 1, 1);
    chk("mode_inc_coinc", 0, 0, 0, 1, 0, 0);
    ticks(2);
    chk("tick_in_set_hour", 0, 0, 0, 1, 0, 0);
    mode_btn(); mode_btn();
    ticks(12);
    chk("run_sec12", 0, 0, 12, 0, 0, 0);
    step(1, 1, 0);
    chk("tick_mode_coinc", 0, 0, 0, 1, 0, 0);

    // Blink in SET_MIN.
    mode_btn();
    ticks(1); chk("blink_1", 0, 0, 0, 2, 1, 0);
    ticks(1); chk("blink_2", 0, 0, 0, 2, 0, 0);
    ticks(1); chk("blink_3", 0, 0, 0, 2, 1, 0);
    step(0, 0, 1);
    chk("inc_clears_blink", 0, 1, 0, 2, 0, 0);
    ticks(1);
    step(1, 1, 0);
    chk("exit_set_min_tick", 0, 1, 0, 0, 0, 0);
    ticks(1);
    chk("resume_count", 0, 1, 1, 0, 0, 0);

    // Reset in the middle of SET_HOUR, between clock edges.
    mode_btn(); incs(7); ticks(1);
    chk("set_hour_7", 7, 1, 0, 1, 1, 0);
    #3 rst = 1;
    #1;
    chk("async_reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #3 rst = 0;
    @(posedge clk); #1;
    ticks(1);
    chk("tick_after_reset", 0, 0, 1, 0, 0, 0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
CLOCK_CTRL -- requirements
Module: clock_ctrl

Interface
REQ-001 The block SHALL have parameter HOUR_MAX, default 23, giving the last hour value before wrap to 0 (legal range 1..31).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port tick, input, 1 bit: one-cycle 1 Hz time-base enable.
REQ-005 The block SHALL have port btn_mode, input, 1 bit: one-cycle, pre-debounced mode-advance pulse.
REQ-006 The block SHALL have port btn_inc, input, 1 bit: one-cycle, pre-debounced increment pulse.
REQ-007 The block SHALL have port sec, output, 6 bits: seconds, binary 0..59.
REQ-008 The block SHALL have port min, output, 6 bits: minutes, binary 0..59.
REQ-009 The block SHALL have port hour, output, 5 bits: hours, binary 0..HOUR_MAX.
REQ-010 The block SHALL have port mode, output, 2 bits: current state; 0=RUN, 1=SET_HOUR, 2=SET_MIN.
REQ-011 The block SHALL have port blink, output, 1 bit: display-blank request for the field being set.
REQ-012 The block SHALL have port day_pulse, output, 1 bit: one-cycle pulse on day rollover.

Function
REQ-013 All outputs SHALL be registered; each output SHALL change in the clock cycle following the qualifying input event.
REQ-014 FSM states SHALL be RUN, SET_HOUR and SET_MIN; encoding 3 SHALL be unreachable and SHALL return to RUN on the next clock.
REQ-015 On btn_mode, the FSM SHALL advance RUN->SET_HOUR->SET_MIN->RUN.
REQ-016 Absent btn_mode, the FSM SHALL hold its state.
REQ-017 In RUN, tick SHALL increment sec.
REQ-018 In RUN, sec at 59 on tick SHALL wrap to 0 and carry +1 into min.
REQ-019 In RUN, min at 59 with carry SHALL wrap to 0 and carry +1 into hour.
REQ-020 In RUN, hour at HOUR_MAX with carry SHALL wrap to 0 and assert day_pulse for exactly one cycle.
REQ-021 Outside RUN, tick SHALL NOT alter sec, min or hour.
REQ-022 On the RUN->SET_HOUR transition, sec SHALL be cleared to 0.
REQ-023 sec SHALL remain 0 throughout both SET states.
REQ-024 In SET_HOUR, btn_inc SHALL increment hour, wrapping HOUR_MAX->0, with no carry and no day_pulse.
REQ-025 In SET_MIN, btn_inc SHALL increment min, wrapping 59->0, with no carry into hour.
REQ-026 In RUN, btn_inc SHALL be ignored.
REQ-027 When btn_mode and btn_inc coincide, the mode change SHALL take effect and btn_inc SHALL be discarded.
REQ-028 When btn_mode and tick coincide in RUN, the transition SHALL occur, sec SHALL be cleared to 0 and the tick SHALL be discarded.
REQ-029 When btn_mode and tick coincide in SET_MIN, the FSM SHALL enter RUN and the tick SHALL be discarded; counting SHALL resume on the next tick.
REQ-030 In RUN, blink SHALL be 0.
REQ-031 In a SET state, blink SHALL toggle on each tick.
REQ-032 blink SHALL be forced to 0 on every state transition.
REQ-033 In a SET state, btn_inc SHALL force blink to 0, so that the field is visible immediately after adjustment.
REQ-034 day_pulse SHALL be asserted only from the RUN carry chain.

Reset
REQ-035 While rst=1, irrespective of clk, the block SHALL hold sec=0, min=0, hour=0, mode=0 (RUN), blink=0 and day_pulse=0.
REQ-036 A reset asserted mid-operation SHALL abort any SET state and discard pending carries.
REQ-037 After rst deasserts, the first tick SHALL give sec=1.

Verification
REQ-038 The bench SHALL cover the full rollover: preset to 23:59:59 via SET, then RUN, then one tick -> 00:00:00 and day_pulse high for exactly one cycle.
REQ-039 The bench SHALL cover minute carry: 10:59:59 plus one tick -> 11:00:00, with no day_pulse.
REQ-040 The bench SHALL cover setting: RUN 05:07:33, then btn_mode, then 20 btn_inc -> hour=1, sec=0; then btn_mode, then 3 btn_inc -> min=10; then btn_mode -> mode=0, time 01:10:00.
REQ-041 The bench SHALL cover coincident events: btn_mode+btn_inc in RUN -> mode=1 with hour unchanged; tick+btn_mode in RUN at sec=12 -> sec=0, mode=1.
REQ-042 The bench SHALL cover blink: in SET_MIN, 3 ticks -> blink 1,0,1; then btn_inc -> blink=0 and min+1; then btn_mode -> blink=0, mode=0.
REQ-043 The bench SHALL cover reset mid-set: in SET_HOUR with hour=7, rst pulse between clock edges -> all outputs 0 immediately, mode=0, first tick after release gives sec=1.
